btn_debounce: RTL
=================

// Module: btn_debounce
// PURPOSE
//   Conditions one raw mechanical push-button input into a clean, glitch-free level.
//   Sits directly upstream of BTN_detect_edge: o_signal drives its i_signal.
//   Provides 2-FF synchronisation, a polarity fix-up to active-high, and a counter-qualified
//   stable-level FSM. Optionally adds a long-press (hold) flag.
// PARAMETERS
//   DEBOUNCE_CYCLES  500_000     cycles a new level must stay stable before it is accepted (>=1; 10 ms @ 50 MHz)
//   ACTIVE_LOW       1           1: raw pin reads 0 when pressed; 0: raw pin reads 1 when pressed
//   HOLD_CYCLES      50_000_000  stable-pressed cycles before o_hold asserts (used only with BTN_DEBOUNCE_HOLD_EN)
//   CNT_W            localparam  $clog2(max(DEBOUNCE_CYCLES,HOLD_CYCLES)+1); not overridable
// PORTS
//   i_clk      in   1  system clock
//   i_rst_n    in   1  asynchronous, active-low reset
//   i_btn_raw  in   1  asynchronous raw button pin
//   o_signal   out  1  debounced level, 1 = pressed (active-high regardless of ACTIVE_LOW)
//   o_busy     out  1  1 while a candidate level change is being qualified
//   o_hold     out  1  long-press flag (tied 0 when BTN_DEBOUNCE_HOLD_EN undefined)
// BEHAVIOUR
//   - Sync: s1<=i_btn_raw, s2<=s1. Reset value of s1/s2 = idle level (ACTIVE_LOW ? 1 : 0),
//     so reset never produces a phantom press. w_in = ACTIVE_LOW ? ~s2 : s2.
//   - FSM states S_LOW, S_RISE, S_HIGH, S_FALL; reset -> S_LOW, cnt=0.
//     S_LOW : w_in=1 -> S_RISE, cnt<=0.
//     S_RISE: w_in=0 -> S_LOW; else cnt==DEBOUNCE_CYCLES-1 -> S_HIGH; else cnt++.
//     S_HIGH: w_in=0 -> S_FALL, cnt<=0.
//     S_FALL: w_in=1 -> S_HIGH; else cnt==DEBOUNCE_CYCLES-1 -> S_LOW; else cnt++.
//   - o_signal = (state==S_HIGH || state==S_FALL); o_busy = (state==S_RISE || state==S_FALL).
//     Both are decoded from the state register only (no combinational path from i_btn_raw).
//   - Latency: o_signal changes exactly DEBOUNCE_CYCLES+2 rising edges after the edge at which
//     s1 first captures the new level, provided the level holds throughout.
//   - Any reversal during S_RISE/S_FALL aborts qualification; counter restarts on the next attempt.
//   - cnt never wraps: it is compared for equality and cleared on every state entry.
//   - Reset asserted mid-operation: all state, cnt and outputs return to reset values immediately
//     (async); o_signal=0, o_busy=0, o_hold=0.
// CONFIGURATION
//   Macro BTN_DEBOUNCE_HOLD_EN:
//   - Defined: separate hold counter, cleared on entry to S_HIGH from S_RISE, increments in
//     S_HIGH/S_FALL, saturates at HOLD_CYCLES. o_hold=1 once it reaches HOLD_CYCLES and stays
//     1 until the FSM enters S_LOW. A glitch S_FALL->S_HIGH does not clear it.
//   - Undefined: no hold counter is synthesised; o_hold is constant 0; HOLD_CYCLES is ignored.
// STRUCTURE
//   - Package btn_pkg: typedef enum logic [1:0] btn_db_state_t {S_LOW,S_RISE,S_HIGH,S_FALL};
//     constants BTN_DEBOUNCE_DEFAULT=500_000 and BTN_HOLD_DEFAULT=50_000_000.
//   - One sub-module, btn_sync2: 2-FF synchroniser with a reset-value parameter.
//   - FSM, counters and output decode are in btn_debounce.
// TESTING  (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=1, macro defined unless noted)
//   1. Reset with raw=1 for 10 cycles -> o_signal=0, o_busy=0, o_hold=0, state stays S_LOW.
//   2. raw 1->0 held 20 cycles -> o_busy=1 from edge +2; o_signal=1 at edge +6; o_busy=0 from then on.
//   3. Bounce: raw low 3 cycles, high 1, low 2, high -> o_signal never 1; o_busy pulses;
//      FSM ends in S_LOW.
//   4. Pressed, then raw high 2 cycles and low again -> o_signal stays 1; S_FALL->S_HIGH seen.
//   5. Press held 20 cycles -> o_hold=1 10 cycles after o_signal rises; on release, o_hold clears
//      with o_signal. With the macro undefined, o_hold stays 0.
//   6. i_rst_n pulled low while in S_RISE (cnt=2) -> all outputs 0 at once; after release and
//      with raw still 0, the full 6-cycle qualification is required again.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Also provides a small max helper used when sizing counters.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } btn_db_state_t;

    localparam int unsigned BTN_DEBOUNCE_DEFAULT = 32'd500_000;
    localparam int unsigned BTN_HOLD_DEFAULT     = 32'd50_000_000;

    function automatic int unsigned btn_max(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchroniser for an asynchronous input.
// The reset value is a parameter so the output starts at the pin's idle level.
module btn_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic s1_q;
    logic s2_q;

    // Metastability filter: two back-to-back capture stages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= i_d;
            s2_q <= s1_q;
        end
    end

    assign o_q = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: sync, polarity fix-up, counter-qualified level FSM.
// Define BTN_DEBOUNCE_HOLD_EN to add the long-press flag on o_hold.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned HOLD_CYCLES     = BTN_HOLD_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    output logic o_signal,
    output logic o_busy,
    output logic o_hold
);

    localparam int CNT_W = $clog2(btn_max(DEBOUNCE_CYCLES, HOLD_CYCLES) + 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic             IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

    btn_db_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_s;
    logic             btn_in_s;
    logic             signal_d, busy_d, hold_d;
    logic             signal_q, busy_q, hold_q;

    btn_sync2 #(.RST_VAL(IDLE_LVL)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_btn_raw),
        .o_q     (sync_s)
    );

    assign btn_in_s = ACTIVE_LOW ? ~sync_s : sync_s;

    // Next-state and qualification counter; cnt is cleared on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW: begin
                if (btn_in_s) begin
                    state_d = S_RISE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = S_LOW;
                end
            end
            S_RISE: begin
                if (!btn_in_s) begin
                    state_d = S_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!btn_in_s) begin
                    state_d = S_FALL;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = S_HIGH;
                end
            end
            S_FALL: begin
                if (btn_in_s) begin
                    state_d = S_HIGH;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies track the state register.
    always_comb begin
        signal_d = (state_d == S_HIGH) || (state_d == S_FALL);
        busy_d   = (state_d == S_RISE) || (state_d == S_FALL);
    end

`ifdef BTN_DEBOUNCE_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // Hold counter: restarts on a fresh press, survives S_FALL glitches, saturates.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if ((state_q == S_RISE) && (state_d == S_HIGH)) begin
            hold_cnt_d = CNT_ZERO;
        end else if (((state_q == S_HIGH) || (state_q == S_FALL)) && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
        hold_d = signal_d && (hold_cnt_d == HOLD_MAX);
    end

    // Hold counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_cnt_q <= CNT_ZERO;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_d = 1'b0;
`endif

    // State, counter and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_LOW;
            cnt_q    <= CNT_ZERO;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            hold_q   <= hold_d;
        end
    end

    assign o_signal = signal_q;
    assign o_busy   = busy_q;
    assign o_hold   = hold_q;

endmodule
